// File: rtl/sweep_pkg.sv
// sweep_pkg: shared state encoding and default widths for the triangle-sweep sequencer.
package sweep_pkg;
    typedef enum logic [1:0] {IDLE, UP, DOWN, DONE} state_e;
    localparam int WIDTH_DEF = 16;
    localparam int CYC_W_DEF = 8;
endpackage

// File: rtl/rev_counter16.sv
// rev_counter16: loadable up/down counter register stepped by the sweep sequencer.
module rev_counter16 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         up,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (rst)       cnt_q <= '0;
        else if (load) cnt_q <= load_val;
        else if (en)   cnt_q <= up ? cnt_q + W'(1) : cnt_q - W'(1);
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: start/stop sequencer running a counter through lo..hi triangle sweeps.
// Optional `pause` input when SWEEP_PAUSE_EN is defined.
module sweep_ctrl
    import sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CYC_W = CYC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
`ifdef SWEEP_PAUSE_EN
    input  logic             pause,
`endif
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CYC_W-1:0] cycles,
    output logic [WIDTH-1:0] cnt,
    output logic             dir,
    output logic             rc,
    output logic             busy,
    output logic             done,
    output logic             err
);
    state_e           state_q;
    logic [WIDTH-1:0] lo_q, hi_q;
    logic [CYC_W-1:0] cycles_q, trip_q, trip_d;
    logic             dir_q, busy_q, done_q, err_q;
    logic             paused, run, at_hi, at_lo, accept, finish, ld, en, up;

`ifdef SWEEP_PAUSE_EN
    assign paused = pause;
`else
    assign paused = 1'b0;
`endif

    always_comb begin
        run    = state_q == UP || state_q == DOWN;
        at_hi  = cnt == hi_q;
        at_lo  = cnt == lo_q;
        accept = state_q == IDLE && start && lo < hi;
        trip_d = trip_q + CYC_W'(1);
        finish = cycles_q != '0 && trip_d == cycles_q;
        ld     = accept;
        en     = run && !stop && !paused && !(state_q == DOWN && at_lo && finish);
        up     = state_q == UP ? !at_hi : at_lo;
        rc     = !paused && ((state_q == UP && at_hi) || (state_q == DOWN && at_lo));
    end

    rev_counter16 #(.W(WIDTH)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (ld),
        .load_val(lo),
        .en      (en),
        .up      (up),
        .cnt     (cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            cycles_q <= '0;
            trip_q   <= '0;
            dir_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= state_q == IDLE && start && !(lo < hi);
            case (state_q)
                IDLE: if (accept) begin
                    lo_q     <= lo;
                    hi_q     <= hi;
                    cycles_q <= cycles;
                    trip_q   <= '0;
                    state_q  <= UP;
                    busy_q   <= 1'b1;
                    dir_q    <= 1'b1;
                end
                UP: if (stop) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    dir_q   <= 1'b0;
                end else if (!paused && at_hi) begin
                    state_q <= DOWN;
                    dir_q   <= 1'b0;
                end
                DOWN: if (stop) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else if (!paused && at_lo) begin
                    trip_q <= trip_d;
                    if (finish) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= UP;
                        dir_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dir  = dir_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
endmodule

// File: tb/tb_sweep_ctrl.sv
// tb_sweep_ctrl: directed vector table plus hand-written stop/pause sequences for sweep_ctrl.
module tb_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, stop, pause;
    logic [15:0] lo, hi, cnt;
    logic [7:0]  cycles;
    logic        dir, rc, busy, done, err;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    sweep_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
`ifdef SWEEP_PAUSE_EN
        .pause (pause),
`endif
        .lo    (lo),
        .hi    (hi),
        .cycles(cycles),
        .cnt   (cnt),
        .dir   (dir),
        .rc    (rc),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    typedef struct {
        logic        rst, start, stop;
        logic [15:0] lo, hi;
        logic [7:0]  cyc;
        logic [15:0] e_cnt;
        logic        e_dir, e_rc, e_busy, e_done, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic r, logic s, logic p, logic [15:0] l, logic [15:0] h,
                                logic [7:0] c, logic [15:0] ec, logic ed, logic er,
                                logic eb, logic edn, logic ee);
        mk = '{r, s, p, l, h, c, ec, ed, er, eb, edn, ee};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [15:0] ec, logic ed, logic er, logic eb,
                         logic edn, logic ee);
        checks++;
        if ({cnt, dir, rc, busy, done, err} !== {ec, ed, er, eb, edn, ee}) begin
            errors++;
            $display("FAIL %s: got cnt=%h dir=%b rc=%b busy=%b done=%b err=%b, want cnt=%h dir=%b rc=%b busy=%b done=%b err=%b",
                     name, cnt, dir, rc, busy, done, err, ec, ed, er, eb, edn, ee);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
        lo = '0; hi = '0; cycles = '0;
        // reset
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 0, 0));
        // lo=3 hi=5 cycles=2 sweep
        vecs.push_back(mk(0, 1, 0, 3, 5, 2, 16'd3, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd4, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd5, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd4, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd3, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd4, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd5, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd4, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd3, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd3, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd3, 0, 0, 0, 0, 0));
        // rejected starts: lo==hi, lo>hi
        vecs.push_back(mk(0, 1, 0, 5, 5, 1, 16'd3, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 5, 5, 1, 16'd3, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 7, 2, 1, 16'd3, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 7, 2, 1, 16'd3, 0, 0, 0, 0, 0));
        // stop exactly at hi
        vecs.push_back(mk(0, 1, 0, 10, 12, 0, 16'd10, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd11, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd12, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'd12, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 16'd12, 0, 0, 0, 0, 0));
        // start while busy is ignored
        vecs.push_back(mk(0, 1, 0, 1, 3, 1, 16'd1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 20, 30, 9, 16'd2, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd3, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd2, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd1, 0, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd1, 0, 0, 0, 0, 0));
        // reset at cnt=4 while counting down
        vecs.push_back(mk(0, 1, 0, 2, 5, 0, 16'd2, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd3, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd4, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd5, 1, 1, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd4, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'd0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; start = vecs[i].start; stop = vecs[i].stop;
            lo = vecs[i].lo; hi = vecs[i].hi; cycles = vecs[i].cyc;
            step();
            check($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_dir, vecs[i].e_rc,
                  vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
        end

        // long free-running sweep stopped at 0x0100
        @(negedge clk);
        start = 1'b1; stop = 1'b0; lo = 16'h0000; hi = 16'hFFFF; cycles = 8'd0;
        step();
        check("long_start", 16'h0000, 1, 0, 1, 0, 0);
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (cnt !== 16'h0100 && n < 1000) begin
                step();
                n++;
            end
            checks++;
            if (n != 256) begin
                errors++;
                $display("FAIL long_reach: got %0d steps cnt=%h, want 256 steps cnt=0100", n, cnt);
            end
        end
        @(negedge clk);
        stop = 1'b1;
        step();
        check("long_stop", 16'h0100, 0, 0, 0, 0, 0);
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("long_hold%0d", i), 16'h0100, 0, 0, 0, 0, 0);
        end

`ifdef SWEEP_PAUSE_EN
        // pause three cycles at cnt=4 on the way up: lo=3 hi=5 one trip
        @(negedge clk);
        start = 1'b1; lo = 16'd3; hi = 16'd5; cycles = 8'd1;
        step();
        check("pz_load", 16'd3, 1, 0, 1, 0, 0);
        @(negedge clk);
        start = 1'b0;
        step();
        check("pz_4", 16'd4, 1, 0, 1, 0, 0);
        @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("pz_hold%0d", i), 16'd4, 1, 0, 1, 0, 0);
        end
        @(negedge clk);
        pause = 1'b0;
        step(); check("pz_5", 16'd5, 1, 1, 1, 0, 0);
        step(); check("pz_d4", 16'd4, 0, 0, 1, 0, 0);
        step(); check("pz_d3", 16'd3, 0, 1, 1, 0, 0);
        step(); check("pz_done", 16'd3, 0, 0, 0, 1, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
